// File: rtl/gpioemu_pkg.sv
// -----------------------------------------------------------------------------
// gpioemu_pkg
// Shared definitions for the arbitrated shift-add multiplier.
//   A_W_DEF / W_W_DEF : default operand width and result word width
//   POP_W             : width of the popcount result (rsp_l)
//   state_t           : control FSM state encoding
//   port_onehot()     : requester index -> one-hot port vector
// -----------------------------------------------------------------------------
package gpioemu_pkg;

    localparam int A_W_DEF = 24;
    localparam int W_W_DEF = 32;
    localparam int POP_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MULT  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [1:0] port_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mul_shift_add.sv
// -----------------------------------------------------------------------------
// mul_shift_add
// Iterative unsigned multiplier: one multiplier bit is examined per cycle,
// A_W cycles per product, full 2*A_W-bit accumulator (no truncation).
//   clk, reset  : clock, asynchronous active-high reset
//   i_start     : load operands and begin; the load happens on this edge
//   i_a1        : multiplicand
//   i_a2        : multiplier
//   o_done      : high during the final iteration cycle; o_product is the
//                 finished product from the following cycle onward
//   o_product   : accumulator, holds its value until the next i_start
// -----------------------------------------------------------------------------
module mul_shift_add
    import gpioemu_pkg::*;
#(
    parameter int A_W = A_W_DEF
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic [A_W-1:0]     i_a1,
    input  logic [A_W-1:0]     i_a2,
    output logic               o_done,
    output logic [2*A_W-1:0]   o_product
);

    localparam int CNT_W = $clog2(A_W) + 1;

    logic [2*A_W-1:0] r_acc;
    logic [2*A_W-1:0] r_mcand;
    logic [A_W-1:0]   r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;

    logic [2*A_W-1:0] w_acc_next;

    // LSB of the shifting multiplier selects whether the shifted
    // multiplicand is added this cycle.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Combinational so the controller can leave MULT on the same edge that
    // performs the last accumulation; keeps the response latency at A_W+2.
    assign o_done    = r_run && (r_cnt == CNT_W'(A_W - 1));
    assign o_product = r_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{A_W{1'b0}}, i_a1};
            r_mplier <= i_a2;
            r_cnt    <= '0;
            r_run    <= 1'b1;
        end else if (r_run) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (o_done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// -----------------------------------------------------------------------------
// mul_arbiter
// Two-port round-robin front end for a shared iterative multiplier. A granted
// request runs A_W shift-add cycles, one popcount cycle, then pulses
// rsp_valid for the owning port. One operation in flight at a time.
//   clk, reset         : clock, asynchronous active-high reset
//   req_valid[1:0]     : per-port request
//   req0_a1, req0_a2   : port-0 operands
//   req1_a1, req1_a2   : port-1 operands
//   req_ready[1:0]     : one-hot grant, only while idle
//   rsp_valid[1:0]     : one-cycle completion pulse to the owner
//   rsp_w              : product bits [W_W-1:0]
//   rsp_l              : number of ones in rsp_w
//   rsp_ovf            : product has bits set above W_W-1
//   busy               : not idle
//   op_count           : completed operations, wraps at 16 bits
// -----------------------------------------------------------------------------
module mul_arbiter
    import gpioemu_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int W_W = W_W_DEF
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    input  logic [A_W-1:0]   req0_a1,
    input  logic [A_W-1:0]   req0_a2,
    input  logic [A_W-1:0]   req1_a1,
    input  logic [A_W-1:0]   req1_a2,
    output logic [1:0]       req_ready,
    output logic [1:0]       rsp_valid,
    output logic [W_W-1:0]   rsp_w,
    output logic [POP_W-1:0] rsp_l,
    output logic             rsp_ovf,
    output logic             busy,
    output logic [15:0]      op_count
);

    // Product viewed at least W_W wide so narrow products still fill rsp_w
    // and wide ones expose their upper bits for the overflow test.
    localparam int P_W = (2 * A_W > W_W) ? 2 * A_W : W_W;

    state_t          r_state;
    logic            r_owner;
    logic            r_last_grant;
    logic            r_busy;
    logic [1:0]      r_rsp_valid;
    logic [W_W-1:0]  r_rsp_w;
    logic [POP_W-1:0] r_rsp_l;
    logic            r_rsp_ovf;
    logic [15:0]     r_op_count;

    logic            w_gnt_idx;
    logic [1:0]      w_ready;
    logic            w_accept;
    logic [A_W-1:0]  w_a1;
    logic [A_W-1:0]  w_a2;
    logic            w_mul_done;
    logic [2*A_W-1:0] w_product;
    logic [P_W-1:0]  w_prod_ext;
    logic [W_W-1:0]  w_prod_lo;
    logic            w_ovf;
    logic [POP_W-1:0] w_pop;

    // ---------------------------------------------------------------------
    // Arbitration: a lone requester always wins; on contention the port that
    // did not win last time gets the grant. Grant is held off during reset so
    // no request can be accepted while the FSM is being cleared.
    // ---------------------------------------------------------------------
    always_comb begin
        w_gnt_idx = 1'b0;
        if (req_valid == 2'b11) begin
            w_gnt_idx = ~r_last_grant;
        end else begin
            w_gnt_idx = req_valid[1];
        end
    end

    always_comb begin
        w_ready = 2'b00;
        if ((r_state == ST_IDLE) && !reset && (req_valid != 2'b00)) begin
            w_ready = port_onehot(w_gnt_idx);
        end
    end

    assign w_accept = |(req_valid & w_ready);
    assign w_a1     = w_gnt_idx ? req1_a1 : req0_a1;
    assign w_a2     = w_gnt_idx ? req1_a2 : req0_a2;

    // Operands are captured inside the multiplier on the accepting edge, so
    // later changes on req_* cannot disturb the operation in flight.
    mul_shift_add #(
        .A_W       (A_W)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_accept),
        .i_a1      (w_a1),
        .i_a2      (w_a2),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    // ---------------------------------------------------------------------
    // Result shaping: low word, overflow and popcount, all from the settled
    // product during COUNT.
    // ---------------------------------------------------------------------
    assign w_prod_ext = P_W'(w_product);
    assign w_prod_lo  = w_prod_ext[W_W-1:0];
    assign w_ovf      = |(w_prod_ext >> W_W);

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < W_W; i++) begin
            w_pop = w_pop + POP_W'(w_prod_lo[i]);
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM
    //   IDLE  -> MULT  on accept
    //   MULT  -> COUNT on the last multiplier iteration
    //   COUNT -> DONE  registers the result and the owner's rsp_valid
    //   DONE  -> IDLE  counts the completion
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_busy       <= 1'b0;
            r_rsp_valid  <= 2'b00;
            r_rsp_w      <= '0;
            r_rsp_l      <= '0;
            r_rsp_ovf    <= 1'b0;
            r_op_count   <= '0;
        end else begin
            r_rsp_valid <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state      <= ST_MULT;
                        r_owner      <= w_gnt_idx;
                        r_last_grant <= w_gnt_idx;
                        r_busy       <= 1'b1;
                    end
                end
                ST_MULT: begin
                    if (w_mul_done) begin
                        r_state <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    r_rsp_w     <= w_prod_lo;
                    r_rsp_l     <= w_pop;
                    r_rsp_ovf   <= w_ovf;
                    r_rsp_valid <= port_onehot(r_owner);
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    r_op_count <= r_op_count + 16'd1;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_w     = r_rsp_w;
    assign rsp_l     = r_rsp_l;
    assign rsp_ovf   = r_rsp_ovf;
    assign busy      = r_busy;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_mul_arbiter.sv
module tb_mul_arbiter;
    import gpioemu_pkg::*;

    localparam int A_W = 24;
    localparam int W_W = 32;
    localparam int LAT = A_W + 2;   // accept-observed cycle to rsp cycle
    localparam int GAP = A_W + 3;   // back-to-back accept spacing

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [1:0]     req_valid = 2'b00;
    logic [A_W-1:0] req0_a1 = '0, req0_a2 = '0, req1_a1 = '0, req1_a2 = '0;
    logic [1:0]     req_ready;
    logic [1:0]     rsp_valid;
    logic [W_W-1:0] rsp_w;
    logic [5:0]     rsp_l;
    logic           rsp_ovf;
    logic           busy;
    logic [15:0]    op_count;

    mul_arbiter #(.A_W(A_W), .W_W(W_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req0_a1   (req0_a1),
        .req0_a2   (req0_a2),
        .req1_a1   (req1_a1),
        .req1_a2   (req1_a2),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_w     (rsp_w),
        .rsp_l     (rsp_l),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           port;
        logic [W_W-1:0] w;
        logic [5:0]     l;
        logic           ovf;
        int             cyc;
    } sb_t;

    typedef struct {
        logic           p;
        logic [A_W-1:0] a1;
        logic [A_W-1:0] a2;
        logic [W_W-1:0] w;
        logic [5:0]     l;
        logic           o;
    } vec_t;

    sb_t            sbq[$];
    int             gport[$];
    int             gcyc[$];
    int             cyc = 0;
    int             n_tests = 0;
    int             n_fail = 0;
    int             exp_cnt = 0;
    int             c0 = 0;
    logic [W_W-1:0] pe_w[2];
    logic [5:0]     pe_l[2];
    logic           pe_o[2];
    vec_t           vt[9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: push expected result on accept, pop and compare on rsp.
    always @(negedge clk) begin
        sb_t e;
        check("ready_onehot_idle", (($countones(req_ready) <= 1) && !(busy && (req_ready != 2'b00))), 1);
        if (!reset && ((req_valid & req_ready) != 2'b00)) begin
            e.port = req_ready[1];
            e.w    = pe_w[e.port];
            e.l    = pe_l[e.port];
            e.ovf  = pe_o[e.port];
            e.cyc  = cyc;
            sbq.push_back(e);
            gport.push_back(int'(e.port));
            gcyc.push_back(cyc);
        end
        if (rsp_valid != 2'b00) begin
            if (sbq.size() == 0) begin
                check("unexpected_rsp", rsp_valid, 0);
            end else begin
                e = sbq.pop_front();
                check("rsp_port", rsp_valid, e.port ? 2'b10 : 2'b01);
                check("rsp_w", rsp_w, e.w);
                check("rsp_l", rsp_l, e.l);
                check("rsp_ovf", rsp_ovf, e.ovf);
                check("rsp_latency", cyc - e.cyc, LAT);
                exp_cnt++;
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_w"}, rsp_w, 0);
        check({tag, "_rsp_l"}, rsp_l, 0);
        check({tag, "_rsp_ovf"}, rsp_ovf, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_op_count"}, op_count, 0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !busy) got = 1;
        end
        check(tag, got, 1);
    endtask

    task automatic do_op(input logic p, input logic [A_W-1:0] a1, input logic [A_W-1:0] a2,
                         input logic [W_W-1:0] ew, input logic [5:0] el, input logic eo);
        bit got = 0;
        @(posedge clk); #1;
        pe_w[p] = ew; pe_l[p] = el; pe_o[p] = eo;
        if (p) begin req1_a1 = a1; req1_a2 = a2; end
        else   begin req0_a1 = a1; req0_a2 = a2; end
        req_valid[p] = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (req_ready[p]) got = 1;
        end
        check("accept_wait", got, 1);
        @(posedge clk); #1;
        // Operands and valid change right after the accept; the result must not.
        req_valid[p] = 1'b0;
        req0_a1 = A_W'($urandom); req0_a2 = A_W'($urandom);
        req1_a1 = A_W'($urandom); req1_a2 = A_W'($urandom);
        wait_idle("complete_wait", 100);
        check("op_count", op_count, 16'(exp_cnt));
        check("rsp_w_hold", rsp_w, ew);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b0, 24'h000003, 24'h000005, 32'h0000000F, 6'd4,  1'b0};
        vt[1] = '{1'b1, 24'hFFFFFF, 24'hFFFFFF, 32'hFE000001, 6'd8,  1'b1};
        vt[2] = '{1'b0, 24'h000000, 24'hABCDEF, 32'h00000000, 6'd0,  1'b0};
        vt[3] = '{1'b1, 24'h000000, 24'h5A5A5A, 32'h00000000, 6'd0,  1'b0};
        vt[4] = '{1'b0, 24'h010000, 24'h010000, 32'h00000000, 6'd0,  1'b1};
        vt[5] = '{1'b1, 24'h800000, 24'h000002, 32'h01000000, 6'd1,  1'b0};
        vt[6] = '{1'b0, 24'h00FFFF, 24'h00FFFF, 32'hFFFE0001, 6'd16, 1'b0};
        vt[7] = '{1'b1, 24'h000001, 24'h000001, 32'h00000001, 6'd1,  1'b0};
        vt[8] = '{1'b0, 24'hFFFFFF, 24'h000100, 32'hFFFFFF00, 6'd24, 1'b0};

        // Contention from reset: port0 3*5, port1 7*9 = 0x3F.
        req0_a1 = 24'd3; req0_a2 = 24'd5;
        req1_a1 = 24'd7; req1_a2 = 24'd9;
        pe_w[0] = 32'h0000000F; pe_l[0] = 6'd4; pe_o[0] = 1'b0;
        pe_w[1] = 32'h0000003F; pe_l[1] = 6'd6; pe_o[1] = 1'b0;
        req_valid = 2'b11;
        #1;
        check_reset_vals("reset");

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        c0 = cyc;
        begin
            bit got = 0;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                if (gport.size() >= 4) got = 1;
            end
            check("contention_4_accepts", got, 1);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_idle("contention_drain", 200);
        if (gport.size() >= 4) begin
            check("grant0", gport[0], 0);
            check("grant1", gport[1], 1);
            check("grant2", gport[2], 0);
            check("grant3", gport[3], 1);
            check("first_accept_after_reset", gcyc[0], c0);
            for (int i = 1; i < 4; i++) check("accept_spacing", gcyc[i] - gcyc[i-1], GAP);
        end
        check("op_count_after_contention", op_count, 4);

        // Request withdrawn before any edge: no state change.
        @(posedge clk); #1 req_valid[1] = 1'b1;
        #3 req_valid[1] = 1'b0;
        @(posedge clk); #1;
        check("withdrawn_busy", busy, 0);
        check("withdrawn_count", op_count, 4);

        for (int i = 0; i < 9; i++) do_op(vt[i].p, vt[i].a1, vt[i].a2, vt[i].w, vt[i].l, vt[i].o);

        // Reset on the 10th MULT cycle aborts the operation.
        @(posedge clk); #1;
        req0_a1 = 24'h000123; req0_a2 = 24'h000456;
        pe_w[0] = 32'hDEADBEEF; pe_l[0] = 6'd0; pe_o[0] = 1'b0;
        req_valid[0] = 1'b1;
        begin
            bit got = 0;
            for (int i = 0; i < 50 && !got; i++) begin
                @(negedge clk);
                if (req_ready[0]) got = 1;
            end
            check("abort_accept_wait", got, 1);
        end
        @(posedge clk); #1 req_valid[0] = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_reset_vals("abort");
        sbq.delete();
        exp_cnt = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_idle_busy", busy, 0);
        check("abort_idle_count", op_count, 0);
        do_op(1'b0, 24'h000123, 24'h000456, 32'h0004EDC2, 6'd10, 1'b0);

        // op_count wrap.
        @(negedge clk);
        force dut.r_op_count = 16'hFFFF;
        #1 release dut.r_op_count;
        exp_cnt = 65535;
        check("op_count_preload", op_count, 16'hFFFF);
        do_op(1'b1, 24'h000002, 24'h000003, 32'h00000006, 6'd2, 1'b0);
        check("op_count_wrap", op_count, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
